bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one shift per clock.
//  Each iteration applies the per-digit add-3 correction cell (+3 when digit >= 5) to every BCD digit.
//  It then shifts the BCD register left by one bit, taking in the next binary MSB.
//  Sits between the binary datapath (counters, score/value registers) and the BCD display decoder.
// PARAMETERS
//  BIN_W   8  width of binary input, >= 1
//  DIGITS  3  number of BCD output digits, >= 1
// PORTS
//  clk      in   1         system clock, rising edge
//  rst      in   1         asynchronous, active-high reset
//  start    in   1         request a conversion of bin_in; sampled on clk rising edge
//  bin_in   in   BIN_W     unsigned binary operand; sampled only when start is accepted
//  busy     out  1         conversion in progress
//  done     out  1         one-cycle pulse; bcd_out (and ovf) valid and updated this cycle
//  bcd_out  out  4*DIGITS  packed BCD result; digit 0 = bits [3:0] (units)
//  ovf      out  1         value >= 10**DIGITS; present only with BIN2BCD_OVF_EN
// BEHAVIOUR
//  Reset (async, any state) gives: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0.
//  Reset also clears the shift registers and bit counter. An aborted conversion produces no done.
//  States and transitions:
//   IDLE  - start=1: latch bin_in into the binary shift reg, clear the BCD work reg,
//           load cnt=BIN_W, go to SHIFT.
//   SHIFT - every cycle: correct each digit d with d>=5 ? d+3 : d (4-bit, no carry to next digit).
//           Then shift {bcd_work, bin_sr} left by 1 and decrement cnt.
//           When cnt reaches 1 this cycle, go to DONE.
//   DONE  - bcd_out <= bcd_work and done=1 for this single cycle.
//           start=1 here is accepted exactly as in IDLE and goes to SHIFT; otherwise go to IDLE.
//  busy=1 only in SHIFT. start is ignored while busy=1 (no queueing, latched operand unchanged).
//  Latency: start accepted at edge k -> done high in the cycle after edge k+BIN_W.
//   Sustained throughput is one result per BIN_W+1 cycles.
//  bcd_out is registered and changes only in the DONE cycle. It holds the last result otherwise.
//  Width rules:
//   cnt is $clog2(BIN_W+1) bits.
//   Bits shifted out of the top digit are discarded, so bcd_out = bin_in mod 10**DIGITS.
//   No corrections are applied after the final shift.
//  BIN_W=1: a single SHIFT cycle, bcd_out = {0..., bin_in}.
// CONFIGURATION
//  BIN2BCD_OVF_EN defined:
//   - ovf port exists.
//   - A sticky internal flag is cleared at start acceptance and set if any 1 is shifted out of the top digit.
//   - ovf is registered alongside bcd_out in the DONE cycle and holds until the next DONE or reset.
//  BIN2BCD_OVF_EN undefined: no ovf port and no flag logic. Truncation behaviour is unchanged.
// TESTING
//  T1 BIN_W=8,DIGITS=3: start with bin_in=0 -> done at k+9, bcd_out=12'h000, busy high 8 cycles.
//  T2 bin_in=255 -> bcd_out=12'h255; then bin_in=99 -> bcd_out=12'h099; sweep 0..255 vs model.
//  T3 start held high continuously with bin_in=137 -> done every 9 cycles, bcd_out=12'h137.
//     bin_in changes while busy do not affect the result.
//  T4 assert rst 4 cycles into a conversion of 200 -> busy=0, done never pulses, bcd_out=0.
//     A new start with 42 then gives 12'h042.
//  T5 BIN_W=10,DIGITS=3, OVF_EN: 999 -> 12'h999, ovf=0; 1000 -> 12'h000, ovf=1;
//     1023 -> 12'h023, ovf=1.
//  T6 start in DONE cycle with bin_in=7 -> no IDLE gap, busy=1 next cycle, next done gives 12'h007.

Source files
------------

// File: rtl/bin2bcd_if.sv
// Handshake bundle between a binary producer and the bin2bcd_seq converter.
// The ovf signal exists only when BIN2BCD_OVF_EN is defined.
interface bin2bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic                  ovf;

    modport master (output start, output bin_in,
                    input busy, input done, input bcd_out, input ovf);
    modport slave  (input start, input bin_in,
                    output busy, output done, output bcd_out, output ovf);
`else
    modport master (output start, output bin_in,
                    input busy, input done, input bcd_out);
    modport slave  (input start, input bin_in,
                    output busy, output done, output bcd_out);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional overflow flag enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  b
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(BIN_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [BIN_W-1:0]        bin_sr;
    logic [BW-1:0]           bcd_work;
    logic [BW-1:0]           bcd_q;
    logic [BW-1:0]           bcd_adj;
    logic [BW+BIN_W-1:0]     shifted;
    logic [CW-1:0]           cnt;
    logic                    accept;
    logic                    last;

    // Per-digit add-3 cell; digits never carry into their neighbour.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [3:0] d;
        add3 = v;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (d >= 4'd5)
                add3[4*i +: 4] = d + 4'd3;
        end
    endfunction

    assign bcd_adj = add3(bcd_work);
    assign shifted = {bcd_adj[BW-2:0], bin_sr, 1'b0};
    assign accept  = (state != SHIFT) && b.start;
    assign last    = (state == SHIFT) && (cnt == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (b.start) state_nxt = SHIFT;
            SHIFT:   if (last)    state_nxt = DONE;
            DONE:    state_nxt = b.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr   <= '0;
            bcd_work <= '0;
            bcd_q    <= '0;
            cnt      <= '0;
        end else if (accept) begin
            bin_sr   <= b.bin_in;
            bcd_work <= '0;
            cnt      <= CNT_INIT;
        end else if (state == SHIFT) begin
            {bcd_work, bin_sr} <= shifted;
            cnt                <= cnt - CNT_ONE;
            // Result is captured on the final shift so it is valid during DONE.
            if (last)
                bcd_q <= shifted[BW+BIN_W-1:BIN_W];
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic ovf_flag;
    logic ovf_q;

    // Any 1 leaving the top digit means the value needs more digits than we have.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            ovf_flag <= 1'b0;
        end else if (state == SHIFT) begin
            ovf_flag <= ovf_flag | bcd_adj[BW-1];
            if (last)
                ovf_q <= ovf_flag | bcd_adj[BW-1];
        end
    end

    assign b.ovf = ovf_q;
`endif

    assign b.busy    = (state == SHIFT);
    assign b.done    = (state == DONE);
    assign b.bcd_out = bcd_q;

endmodule
